board_m: RTL and testbench

Game-state holder for tic-tac-toe and the receiving end of the move bus.
- Samples `update_loc`, `submit` and `reset` from whichever side `turn` enables (player or ai); the bus is low when undriven.
- Validates each move, stores marks, detects win or draw, then hands the turn to the other side.
- Sits between `player_m` and the ai module; its `turn` output is the tri-state enable both drivers use.

---
 rtl/board_m.sv | 145 ++++++++++++++
 tb/tb_board_m.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/board_m.sv
// Tic-tac-toe game-state holder: samples the shared move bus, validates and stores marks, detects win/draw.
// Optional BOARD_ILLEGAL_FORFEIT_EN: a rejected move in S_WAIT forfeits the game to the other side.
module board_m #(
    localparam int unsigned CELLS   = 9,
    localparam int unsigned IDX_W   = 4,
    localparam int unsigned CELLS_W = 2 * CELLS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IDX_W-1:0]   update_loc,
    input  logic               submit,
    input  logic               reset,
    output logic               turn,
    output logic [CELLS_W-1:0] cells,
    output logic [3:0]         move_count,
    output logic [1:0]         winner,
    output logic               game_over,
    output logic               illegal
);

    typedef enum logic [1:0] {S_WAIT, S_EVAL, S_OVER} state_t;

    state_t             r_state, w_state_n;
    logic               r_submit_s, r_submit_q, r_reset_s;
    logic [IDX_W-1:0]   r_loc_s;
    logic [CELLS_W-1:0] r_cells, w_cells_n;
    logic [3:0]         r_move_count, w_move_count_n;
    logic [1:0]         r_winner, w_winner_n;
    logic               r_turn, w_turn_n;
    logic               r_game_over;
    logic               r_illegal, w_illegal_n;
    logic               w_edge, w_occ, w_legal;
    logic [1:0]         w_mark;

    // True when mark m fills any of the eight 3-in-a-row lines.
    function automatic logic has_line(input logic [CELLS_W-1:0] c, input logic [1:0] m);
        logic [CELLS-1:0] o;
        for (int k = 0; k < CELLS; k++) o[k] = (c[2*k +: 2] == m);
        return (o[0] & o[1] & o[2]) | (o[3] & o[4] & o[5]) | (o[6] & o[7] & o[8]) |
               (o[0] & o[3] & o[6]) | (o[1] & o[4] & o[7]) | (o[2] & o[5] & o[8]) |
               (o[0] & o[4] & o[8]) | (o[2] & o[4] & o[6]);
    endfunction

    assign w_edge = r_submit_s & ~r_submit_q;
    assign w_mark = r_turn ? 2'b10 : 2'b01;

    // Occupancy of the addressed cell; out-of-range locations are never occupied, just illegal.
    always_comb begin
        w_occ = 1'b0;
        for (int k = 0; k < CELLS; k++) begin
            if (r_loc_s == IDX_W'(k)) w_occ = |r_cells[2*k +: 2];
        end
    end

    assign w_legal = (r_loc_s <= IDX_W'(8)) && !w_occ;

    always_comb begin
        w_state_n      = r_state;
        w_cells_n      = r_cells;
        w_move_count_n = r_move_count;
        w_winner_n     = r_winner;
        w_turn_n       = r_turn;
        w_illegal_n    = 1'b0;
        if (w_edge && r_reset_s) begin
            w_state_n      = S_WAIT;
            w_cells_n      = '0;
            w_move_count_n = 4'd0;
            w_winner_n     = 2'b00;
            w_turn_n       = 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (w_edge) begin
                        if (w_legal) begin
                            for (int k = 0; k < CELLS; k++) begin
                                if (r_loc_s == IDX_W'(k)) w_cells_n[2*k +: 2] = w_mark;
                            end
                            w_move_count_n = r_move_count + 4'd1;
                            w_state_n      = S_EVAL;
                        end else begin
                            w_illegal_n = 1'b1;
`ifdef BOARD_ILLEGAL_FORFEIT_EN
                            w_winner_n  = r_turn ? 2'b01 : 2'b10;
                            w_state_n   = S_OVER;
`endif
                        end
                    end
                end
                S_EVAL: begin
                    if (has_line(r_cells, w_mark)) begin
                        w_winner_n = w_mark;
                        w_state_n  = S_OVER;
                    end else if (r_move_count == 4'd9) begin
                        w_winner_n = 2'b11;
                        w_state_n  = S_OVER;
                    end else begin
                        w_turn_n  = ~r_turn;
                        w_state_n = S_WAIT;
                    end
                end
                S_OVER: begin
                    if (w_edge) w_illegal_n = 1'b1;
                end
                default: w_state_n = S_WAIT;
            endcase
        end
    end

    // Bus inputs are sampled once, then acted on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_WAIT;
            r_submit_s   <= 1'b0;
            r_submit_q   <= 1'b0;
            r_reset_s    <= 1'b0;
            r_loc_s      <= '0;
            r_cells      <= '0;
            r_move_count <= 4'd0;
            r_winner     <= 2'b00;
            r_turn       <= 1'b0;
            r_game_over  <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_submit_s   <= submit;
            r_submit_q   <= r_submit_s;
            r_reset_s    <= reset;
            r_loc_s      <= update_loc;
            r_cells      <= w_cells_n;
            r_move_count <= w_move_count_n;
            r_winner     <= w_winner_n;
            r_turn       <= w_turn_n;
            r_game_over  <= (w_winner_n != 2'b00);
            r_illegal    <= w_illegal_n;
        end
    end

    assign turn       = r_turn;
    assign cells      = r_cells;
    assign move_count = r_move_count;
    assign winner     = r_winner;
    assign game_over  = r_game_over;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_board_m.sv
// Scoreboard bench for board_m: a behavioural game model predicts each move's outcome.
module tb_board_m;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  update_loc = 4'd0;
    logic        submit = 1'b0;
    logic        reset = 1'b0;
    logic        turn;
    logic [17:0] cells;
    logic [3:0]  move_count;
    logic [1:0]  winner;
    logic        game_over;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [17:0] cells;
        logic [3:0]  mc;
        logic        ill;
        logic        turn;
        logic [1:0]  win;
        logic        go;
    } exp_t;

    exp_t sb[$];

    int m_board[9];
    int m_turn, m_mc, m_win;

    board_m dut (
        .clk(clk), .rst_n(rst_n), .update_loc(update_loc), .submit(submit), .reset(reset),
        .turn(turn), .cells(cells), .move_count(move_count), .winner(winner),
        .game_over(game_over), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < 9; k++) m_board[k] = 0;
        m_turn = 0; m_mc = 0; m_win = 0;
    endfunction

    function automatic logic [17:0] model_cells();
        logic [17:0] c;
        c = '0;
        for (int k = 0; k < 9; k++) c[2*k +: 2] = 2'(m_board[k]);
        return c;
    endfunction

    function automatic bit model_won(input int m);
        int ln[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
        for (int i = 0; i < 8; i++)
            if (m_board[ln[i][0]] == m && m_board[ln[i][1]] == m && m_board[ln[i][2]] == m)
                return 1'b1;
        return 1'b0;
    endfunction

    // Applies one submit to the model and pushes the predicted outcome.
    function automatic void model_push(input int loc, input bit rst);
        exp_t e;
        int   mark;
        e.ill = 1'b0;
        if (rst) begin
            model_clear();
        end else if (m_win != 0) begin
            e.ill = 1'b1;
        end else if (loc > 8 || m_board[loc] != 0) begin
            e.ill = 1'b1;
`ifdef BOARD_ILLEGAL_FORFEIT_EN
            m_win = (m_turn == 0) ? 2 : 1;
`endif
        end else begin
            mark = (m_turn == 0) ? 1 : 2;
            m_board[loc] = mark;
            m_mc++;
            if (model_won(mark)) m_win = mark;
            else if (m_mc == 9) m_win = 3;
            else m_turn = 1 - m_turn;
        end
        e.cells = model_cells();
        e.mc    = 4'(m_mc);
        e.turn  = m_turn[0];
        e.win   = 2'(m_win);
        e.go    = (m_win != 0);
        sb.push_back(e);
    endfunction

    // Drive one submit edge at a falling edge and check both response phases.
    task automatic move(input int loc, input bit rst, input int hold);
        exp_t e;
        model_push(loc, rst);
        update_loc = 4'(loc);
        reset      = rst;
        submit     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check("cells", 32'(cells), 32'(e.cells));
        check("move_count", 32'(move_count), 32'(e.mc));
        check("illegal", 32'(illegal), 32'(e.ill));
        @(negedge clk);
        check("turn", 32'(turn), 32'(e.turn));
        check("winner", 32'(winner), 32'(e.win));
        check("game_over", 32'(game_over), 32'(e.go));
        check("illegal_1cyc", 32'(illegal), 32'd0);
        repeat (hold) @(negedge clk);
        submit = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        if (hold > 0) check("hold_cells", 32'(cells), 32'(e.cells));
        if (hold > 0) check("hold_move_count", 32'(move_count), 32'(e.mc));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cells"}, 32'(cells), 32'd0);
        check({tag, "_turn"}, 32'(turn), 32'd0);
        check({tag, "_winner"}, 32'(winner), 32'd0);
        check({tag, "_game_over"}, 32'(game_over), 32'd0);
        check({tag, "_move_count"}, 32'(move_count), 32'd0);
        check({tag, "_illegal"}, 32'(illegal), 32'd0);
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("por");

        // Player wins on the top row; further move is rejected.
        move(0, 0, 0); move(3, 0, 0); move(1, 0, 0); move(4, 0, 0); move(2, 0, 0);
        move(8, 0, 0);
        move(0, 1, 0);

        // Rejects: out-of-range by the player, occupied cell by the ai.
        move(9, 0, 0);
        move(0, 0, 0);
        move(0, 0, 0);
        move(0, 1, 0);

        // Full draw.
        move(0, 0, 0); move(1, 0, 0); move(2, 0, 0); move(4, 0, 0); move(3, 0, 0);
        move(5, 0, 0); move(7, 0, 0); move(6, 0, 0); move(8, 0, 0);
        move(0, 1, 0);

        // Level held high for several cycles counts as one move.
        move(4, 0, 5);

        // rst_n asserted while the board is evaluating a move.
        update_loc = 4'd5;
        submit     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("eval_cells_written", 32'(cells[11:10]), 32'd2);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async");
        model_clear();
        submit = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        move(8, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
